// File: rtl/dmem_bist_pkg.sv
// Shared types and helpers for the data-memory BIST engine.
//   state_t     : engine sequencing states
//   mode_t      : data pattern select
//   LFSR_POLY   : Galois feedback mask for x^32+x^22+x^2+x+1
//   lfsr_next() : one right-shifting Galois LFSR step
package dmem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ADDR    = 2'd0,
    NADDR   = 2'd1,
    LFSR    = 2'd2,
    CHECKER = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] CHECKER_WORD = 32'h5555_5555;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/dmem_bist_patgen.sv
// Pattern generator for the BIST engine; one instance serves both the
// write pass and the expected-data stream of the read pass.
//   clk, rst_n : clock, asynchronous active-low reset
//   init       : reload the LFSR from seed (seed 0 becomes 1); wins over step
//   step       : advance the LFSR by one word
//   mode       : pattern select (already latched by the caller)
//   seed       : LFSR seed
//   addr       : current word address
//   data       : pattern word for addr (combinational from addr/LFSR state)
module dmem_bist_patgen
  import dmem_bist_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] seed_ext, addr_ext, word;

  always_comb begin
    seed_ext = 32'(seed);
    lfsr_d   = lfsr_q;
    if (init) begin
      lfsr_d = (seed_ext == '0) ? 32'd1 : seed_ext;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    addr_ext = 32'(addr);
    word     = '0;
    unique case (mode)
      ADDR:    word = addr_ext;
      NADDR:   word = ~addr_ext;
      LFSR:    word = lfsr_q;
      CHECKER: word = addr[0] ? ~CHECKER_WORD : CHECKER_WORD;
      default: word = '0;
    endcase
    data = word[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= '0;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/dmem_bist.sv
// Data-memory built-in self-test: writes a pattern to every word, reads
// every word back and compares against the regenerated pattern.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   start, mode, seed   : request a pass; mode/seed latched on acceptance
//   busy, done, pass    : status; done/pass held until the next start
//   err_cnt             : number of mismatching words
//   fail_addr/fail_data : address and read data of the first mismatch
//   mem_we/re/addr/wdata: memory port strobes, address, write data
//   mem_rdata           : read data, valid RD_LAT cycles after mem_re
module dmem_bist
  import dmem_bist_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          drain_q, drain_d;
  mode_t               mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;

  // Expected-data delay line: travels alongside the read request so the
  // compare lines up with mem_rdata RD_LAT cycles later.
  logic                dl_vld_q  [RD_LAT];
  logic                dl_vld_d  [RD_LAT];
  logic [ADDR_W-1:0]   dl_addr_q [RD_LAT];
  logic [ADDR_W-1:0]   dl_addr_d [RD_LAT];
  logic [DATA_W-1:0]   dl_data_q [RD_LAT];
  logic [DATA_W-1:0]   dl_data_d [RD_LAT];

  logic                accept, last_addr, mismatch;
  logic                pg_init, pg_step;
  logic [DATA_W-1:0]   pg_seed, pg_data;

  dmem_bist_patgen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_patgen (
    .clk   (CLK),
    .rst_n (RST_N),
    .init  (pg_init),
    .step  (pg_step),
    .mode  (mode_q),
    .seed  (pg_seed),
    .addr  (addr_q),
    .data  (pg_data)
  );

  always_comb begin
    dl_vld_d[0]  = re_q;
    dl_addr_d[0] = addr_q;
    dl_data_d[0] = pg_data;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
      dl_data_d[i] = dl_data_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    we_d        = we_q;
    re_d        = re_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pg_init     = 1'b0;
    pg_step     = 1'b0;
    pg_seed     = seed_q;

    accept    = start && ((state_q == IDLE) || (state_q == DONE));
    last_addr = (addr_q == LAST_ADDR);
    mismatch  = dl_vld_q[RD_LAT-1] && (mem_rdata != dl_data_q[RD_LAT-1]);

    if (mismatch) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
      if (err_cnt_q == '0) begin
        fail_addr_d = dl_addr_q[RD_LAT-1];
        fail_data_d = mem_rdata;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d     = WRITE;
          mode_d      = mode_t'(mode);
          seed_d      = seed;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          we_d        = 1'b1;
          addr_d      = '0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          // Patgen is seeded from the raw input: seed_q is not yet loaded.
          pg_init     = 1'b1;
          pg_seed     = seed;
        end
      end
      WRITE: begin
        if (last_addr) begin
          state_d = READ;
          we_d    = 1'b0;
          re_d    = 1'b1;
          addr_d  = '0;
          pg_init = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          pg_step = 1'b1;
        end
      end
      READ: begin
        pg_step = 1'b1;
        if (last_addr) begin
          state_d = DRAIN;
          re_d    = 1'b0;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the next count so the final compare cycle is included.
          pass_d  = (err_cnt_d == '0);
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      drain_q     <= '0;
      mode_q      <= ADDR;
      seed_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      dl_vld_q    <= '{default: 1'b0};
      dl_addr_q   <= '{default: '0};
      dl_data_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      we_q        <= we_d;
      re_q        <= re_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      dl_vld_q    <= dl_vld_d;
      dl_addr_q   <= dl_addr_d;
      dl_data_q   <= dl_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = we_q ? pg_data : '0;

endmodule

// File: tb/tb_dmem_bist.sv
// Bench for dmem_bist: behavioural memory with injectable read faults,
// expected writes/reads/results queued at each start, checked by a monitor.
module tb_dmem_bist;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 32;
  localparam int RD_LAT   = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int BUSY_CYC = 2 * DEPTH + RD_LAT;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  dmem_bist #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model with read faults ----------------
  int          fault_kind = 0;  // 0 none, 1 addr6 bit0 forced, 2 stuck-at-0, 3 bit flip
  int          flip_addr  = 0;
  logic [31:0] flip_mask  = 32'd1;
  logic [31:0] mem   [DEPTH];
  logic [31:0] rpipe [RD_LAT];

  function automatic logic [31:0] read_fault(input int a, input logic [31:0] d);
    case (fault_kind)
      1:       return (a == 6) ? (d | 32'd1) : d;
      2:       return 32'd0;
      3:       return (a == flip_addr) ? (d ^ flip_mask) : d;
      default: return d;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= mem_re ? read_fault(int'(mem_addr), mem[mem_addr]) : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { logic ok; int errs; int fa; logic [31:0] fd; } res_t;
  wr_t  wq[$];
  int   rq[$];
  res_t res_q[$];

  function automatic logic [31:0] ref_lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;  // x^32+x^22+x^2+x+1
    return n;
  endfunction

  task automatic issue(input int m, input logic [31:0] sd);
    logic [31:0] lf, w, r;
    res_t e;
    lf = (sd == 32'd0) ? 32'd1 : sd;
    e.errs = 0; e.fa = 0; e.fd = 32'd0;
    for (int a = 0; a < DEPTH; a++) begin
      case (m)
        0:       w = a;
        1:       w = ~a;
        2:       w = lf;
        default: w = (a % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      endcase
      wq.push_back('{a, w});
      rq.push_back(a);
      r = read_fault(a, w);
      if (r !== w) begin
        if (e.errs == 0) begin e.fa = a; e.fd = r; end
        e.errs++;
      end
      lf = ref_lfsr_step(lf);
    end
    e.ok = (e.errs == 0);
    res_q.push_back(e);
    @(negedge CLK);
    start = 1'b1; mode = m[1:0]; seed = sd;
    @(negedge CLK);
    start = 1'b0;
    check("start_we",      64'(mem_we),  64'd1);
    check("start_addr",    64'(mem_addr), 64'd0);
    check("start_busy",    64'(busy),    64'd1);
    check("start_done",    64'(done),    64'd0);
    check("start_errcnt",  64'(err_cnt), 64'd0);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < BUSY_CYC + 20 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    check("done_timeout", 64'(seen), 64'd1);
    @(negedge CLK);
    check("done_held", 64'(done), 64'd1);
  endtask

  // Monitor: pops expectations as the DUT presents strobes and results.
  initial begin
    int  busy_cnt = 0;
    bit  done_prev = 1'b0, busy_prev = 1'b0;
    wr_t w;
    res_t e;
    forever begin
      @(negedge CLK);
      if (RST_N !== 1'b1) begin
        busy_cnt = 0; done_prev = 1'b0; busy_prev = 1'b0;
      end else begin
        check("we_re_excl", 64'(mem_we & mem_re), 64'd0);
        if (!mem_we && !mem_re) check("idle_addr", 64'(mem_addr), 64'd0);
        if (mem_we) begin
          if (wq.size() == 0) check("unexpected_write", 64'd1, 64'd0);
          else begin
            w = wq.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(w.addr));
            check("wr_data", 64'(mem_wdata), 64'(w.data));
          end
        end
        if (mem_re) begin
          if (rq.size() == 0) check("unexpected_read", 64'd1, 64'd0);
          else check("rd_addr", 64'(mem_addr), 64'(rq.pop_front()));
        end
        if (busy) busy_cnt++;
        if (done && !done_prev) begin
          check("done_after_busy", {62'd0, busy_prev, busy}, 64'd2);
          check("busy_cycles", 64'(busy_cnt), 64'(BUSY_CYC));
          check("writes_drained", 64'(wq.size() + rq.size()), 64'd0);
          busy_cnt = 0;
          if (res_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
          else begin
            e = res_q.pop_front();
            check("pass",      64'(pass),      64'(e.ok));
            check("err_cnt",   64'(err_cnt),   64'(e.errs));
            check("fail_addr", 64'(fail_addr), 64'(e.fa));
            check("fail_data", 64'(fail_data), 64'(e.fd));
          end
        end
        done_prev = done;
        busy_prev = busy;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, {45'd0, busy, done, pass, err_cnt, fail_addr}, 64'd0);
    check({tag, "_fdata"},  64'(fail_data), 64'd0);
    check({tag, "_strobe"}, {57'd0, mem_we, mem_re, mem_addr}, 64'd0);
    check({tag, "_wdata"},  64'(mem_wdata), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Clean address pattern, then single forced bit at address 6.
    fault_kind = 0; issue(0, 32'h1234_5678); wait_done();
    fault_kind = 1; issue(0, 32'd0);         wait_done();

    // LFSR with seed 0 (replaced by 1) and seed 1: identical sequences.
    fault_kind = 0; issue(2, 32'd0); wait_done();
    issue(2, 32'd1); wait_done();

    // Checkerboard against stuck-at-0 reads, then clean inverted address.
    fault_kind = 2; issue(3, 32'd0); wait_done();
    fault_kind = 0; issue(1, 32'd0); wait_done();

    // Randomized passes, optionally with one flipped bit.
    for (int k = 0; k < 5; k++) begin
      fault_kind = ($urandom_range(0, 1) == 1) ? 3 : 0;
      flip_addr  = $urandom_range(0, DEPTH - 1);
      flip_mask  = 32'd1 << $urandom_range(0, 31);
      issue($urandom_range(0, 3), $urandom());
      wait_done();
    end
    fault_kind = 0;

    // Start pulse during WRITE must be ignored.
    issue(0, 32'd0);
    repeat (5) @(negedge CLK);
    start = 1'b1; mode = 2'd1; seed = 32'hFFFF_FFFF;
    @(negedge CLK);
    start = 1'b0; mode = 2'd0;
    wait_done();

    // Reset during READ at address 10.
    issue(2, 32'hACE1_0001);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (mem_re && mem_addr == ADDR_W'(10)) found = 1'b1;
    end
    check("reach_read10", 64'(found), 64'd1);
    #1 RST_N = 1'b0;
    #1 check_all_zero("midreset");
    wq.delete(); rq.delete(); res_q.delete();
    @(negedge CLK);
    check_all_zero("held_reset");
    RST_N = 1'b1;
    @(negedge CLK);
    issue(3, 32'd0); wait_done();

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bist.md
# dmem_bist

Parametrised built-in self-test engine for the data memory. It runs a complete write-all / read-all / compare pass against a memory port in hardware, so a single start pulse replaces bench-driven load/store sequences. It sits between the core's data-memory port and the memory macro, behind a test-mode mux. It supports configurable data width, depth, read latency and four data patterns, and reports pass/fail, mismatch count and the first failing location.

## Interface
Parameters:
- DATA_W, 32, memory word width; must be ≤ 32.
- ADDR_W, 5, memory address width.
- DEPTH, 32, number of words tested, addresses 0..DEPTH-1; must be ≤ 2**ADDR_W.
- RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..4.
- CNT_W, $clog2(DEPTH+1), width of err_cnt.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a test pass.
- mode  in  2  pattern select, sampled with start.
- seed  in  DATA_W  LFSR seed, sampled with start.
- busy  out  1  test in progress.
- done  out  1  pass finished; held until next accepted start.
- pass  out  1  valid when done; 1 = no mismatches.
- err_cnt  out  CNT_W  number of mismatching words.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  read data at the first mismatch.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_re.

## Operation
- FSM states: IDLE → WRITE → READ → DRAIN → DONE.
- DONE returns to WRITE on start. No other path returns to IDLE except reset.
- start is accepted only in IDLE or DONE; it is ignored while busy.
- On acceptance, mode and seed are latched, and err_cnt, fail_* and pass are cleared.
- WRITE: one write per cycle at addresses 0..DEPTH-1 with pattern data, then move to READ.
- READ: one read per cycle at addresses 0..DEPTH-1, then move to DRAIN.
- DRAIN: lasts RD_LAT cycles so the final read data can be compared.
- Patterns, for address a at word index a:
  - mode 0: a, zero-extended.
  - mode 1: ~a, over DATA_W bits.
  - mode 2: Galois LFSR, 32-bit, polynomial x^32+x^22+x^2+x+1. Word 0 = seed; seed 0 is replaced by 1. Data = low DATA_W bits; one step per word.
  - mode 3: checkerboard. {DATA_W/2{2'b01}} for even a, inverse for odd a.
- Expected data: the pattern generator is re-initialised on READ entry. Its output travels through an RD_LAT-deep delay line alongside a valid bit and the address.
- Compare: performed each cycle the delayed valid bit is 1. On mismatch, err_cnt increments. If err_cnt was 0, fail_addr and fail_data are captured.
- Entering DONE: pass is set to (err_cnt==0). This uses the count including the final compare cycle.
- err_cnt cannot overflow, because CNT_W covers DEPTH.

## Timing
- Reset values: all outputs are 0, and the FSM is in IDLE.
- Reset is asynchronous, including during an active pass: mem_we and mem_re drop immediately, and no partial result is retained.
- In the cycle after start is sampled, mem_we=1 and mem_addr=0.
- busy is high for exactly 2*DEPTH+RD_LAT cycles.
- done and pass rise in the cycle after the last DRAIN cycle.
- mem_we and mem_re are never high in the same cycle.
- mem_addr is 0 whenever neither strobe is high.
- A start accepted in DONE clears done in the next cycle.

## Structure
- Package dmem_bist_pkg holds:
  - state_t enum;
  - mode_t enum: ADDR, NADDR, LFSR, CHECKER;
  - LFSR_POLY constant;
  - lfsr_next() function.
- Sub-module dmem_bist_patgen generates the pattern. Inputs: clk, rst_n, init, step, mode, seed, addr. Output: data. A single instance is shared by the write and read phases.
- The delay line and compare logic are implemented in the top module.

## Test plan
Scenarios use DEPTH=32, DATA_W=32 and a zero-fault behavioural memory model unless stated.
- Clean run, mode 0, RD_LAT=1 → busy for 65 cycles; mem_wdata at addr 5 = 0x00000005; done=1, pass=1, err_cnt=0.
- Fault injection: mode 0, model forces bit 0 of read addr 6 to 1 → err_cnt=1, fail_addr=6, fail_data=0x00000007, pass=0.
- LFSR mode: build with RD_LAT=3, start twice in mode 2, first run seed=0, second run seed=1 → both write sequences start at 0x00000001 and match the reference lfsr_next(); busy for 67 cycles; pass=1.
- Checkerboard with all reads stuck at 0, mode 3 → err_cnt=32, fail_addr=0, fail_data=0x00000000, pass=0.
- Reset mid-READ: RST_N low while mem_addr=10 → all outputs 0 in the same cycle; after release, a new start completes with pass=1.
- Restart protection: start pulsed during WRITE → ignored, and busy still totals 65 cycles. Start in DONE → done=0 next cycle, and the second pass completes normally.
